fp_result_pack: RTL and testbench

Output stage of the FP32 add/sub datapath, at the consuming end of the special-case select codes.
- Takes the 2-bit sign/exponent/mantissa select codes from the special-case unit, plus the normal-path sign/exponent/fraction from the normaliser/rounder.
- Packs them into the final IEEE-754 single-precision word with per-result exception flags.
- Buffers the result in a 2-entry skid FIFO behind a valid/ready handshake.

---
 rtl/fp_result_pack.sv | 140 ++++++++++++++
 tb/tb_fp_result_pack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fp_result_pack.sv
// rtl/fp_result_pack.sv - FP32 add/sub result packer with flags and skid FIFO (optional sticky flags: FP_PACK_STICKY_EN)
module fp_result_pack #(
    parameter int          DEPTH     = 2,
    parameter logic [22:0] QNAN_FRAC = 23'h400000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [1:0]  i_sel_sign,
    input  logic [1:0]  i_sel_exp,
    input  logic [1:0]  i_sel_man,
    input  logic        i_sign_norm,
    input  logic [7:0]  i_exp_norm,
    input  logic [22:0] i_man_norm,
    input  logic        i_overflow,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic        o_flag_invalid,
    output logic        o_flag_overflow,
    output logic        o_flag_zero,
    input  logic        i_sticky_clr,
    output logic [2:0]  o_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [1:0] SEL_NORM = 2'b00;
    localparam logic [1:0] SEL_ZERO = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    logic        pk_sign;
    logic [7:0]  pk_exp;
    logic [22:0] pk_frac;
    logic [31:0] pk_word;
    logic        pk_reserved;
    logic        pk_ovf;
    logic        pk_inv;
    logic        pk_zero;
    logic [35:0] pk_entry;

    always_comb begin
        pk_sign = 1'b0;
        pk_exp  = 8'h00;
        pk_frac = 23'h0;
        case (i_sel_sign)
            SEL_NORM: pk_sign = i_sign_norm;
            SEL_ONE:  pk_sign = 1'b1;
            default:  pk_sign = 1'b0;
        endcase
        case (i_sel_exp)
            SEL_NORM: pk_exp = i_exp_norm;
            SEL_ONE:  pk_exp = 8'hFF;
            default:  pk_exp = 8'h00;
        endcase
        case (i_sel_man)
            SEL_NORM: pk_frac = i_man_norm;
            SEL_ONE:  pk_frac = QNAN_FRAC;
            default:  pk_frac = 23'h0;
        endcase

        // Reserved select beats the overflow override
        pk_reserved = (i_sel_sign == SEL_RSVD) || (i_sel_exp == SEL_RSVD) || (i_sel_man == SEL_RSVD);
        pk_ovf      = i_overflow && (i_sel_exp == SEL_NORM) && !pk_reserved;
        if (pk_reserved)
            pk_word = 32'h7FC00000;
        else if (pk_ovf)
            pk_word = {pk_sign, 8'hFF, 23'h0};
        else
            pk_word = {pk_sign, pk_exp, pk_frac};

        pk_inv   = (pk_word[30:23] == 8'hFF) && (pk_word[22:0] != 23'h0);
        pk_zero  = (pk_word[30:23] == 8'h00) && (pk_word[22:0] == 23'h0);
        pk_entry = {pk_reserved, pk_ovf, pk_inv, pk_zero, pk_word};
    end

    logic [35:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [35:0]   head;

    assign o_in_ready  = (count != CW'(DEPTH));
    assign o_out_valid = (count != '0);
    assign push        = i_in_valid && o_in_ready;
    assign pop         = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= pk_entry;
    end

    // Gating by valid keeps stale storage invisible after reset
    assign head            = o_out_valid ? mem[rd_ptr] : 36'h0;
    assign o_result        = head[31:0];
    assign o_flag_zero     = head[32];
    assign o_flag_invalid  = head[33];
    assign o_flag_overflow = head[34];

`ifdef FP_PACK_STICKY_EN
    logic [2:0] sticky;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            sticky <= 3'b0;
        else
            sticky <= (i_sticky_clr ? 3'b0 : sticky) | (pop ? {head[33], head[34], head[35]} : 3'b0);
    end

    assign o_sticky = sticky;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = i_sticky_clr;
    assign o_sticky          = 3'b0;
`endif

endmodule

// File: tb/tb_fp_result_pack.sv
// tb/tb_fp_result_pack.sv - directed self-checking bench for fp_result_pack
module tb_fp_result_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel_sign, sel_exp, sel_man;
    logic        sign_norm;
    logic [7:0]  exp_norm;
    logic [22:0] man_norm;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid, flag_overflow, flag_zero;
    logic        sticky_clr;
    logic [2:0]  sticky;

    int n_checks = 0;
    int n_errors = 0;

    fp_result_pack dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_sel_sign      (sel_sign),
        .i_sel_exp       (sel_exp),
        .i_sel_man       (sel_man),
        .i_sign_norm     (sign_norm),
        .i_exp_norm      (exp_norm),
        .i_man_norm      (man_norm),
        .i_overflow      (overflow),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_result        (result),
        .o_flag_invalid  (flag_invalid),
        .o_flag_overflow (flag_overflow),
        .o_flag_zero     (flag_zero),
        .i_sticky_clr    (sticky_clr),
        .o_sticky        (sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ss, input logic [1:0] se, input logic [1:0] sm,
                         input logic sg, input logic [7:0] e, input logic [22:0] m, input logic ov);
        sel_sign  = ss;
        sel_exp   = se;
        sel_man   = sm;
        sign_norm = sg;
        exp_norm  = e;
        man_norm  = m;
        overflow  = ov;
    endtask

    // Presents one word for a single cycle; FIFO assumed not full
    task automatic send(input logic [1:0] ss, input logic [1:0] se, input logic [1:0] sm,
                        input logic sg, input logic [7:0] e, input logic [22:0] m, input logic ov);
        drive(ss, se, sm, sg, e, m, ov);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] w,
                              input logic inv, input logic ovf, input logic zer);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_result"}, result, w);
        check({tag, "_flags"}, {29'h0, flag_invalid, flag_overflow, flag_zero}, {29'h0, inv, ovf, zer});
    endtask

    logic [31:0] got_q[$];
    logic [31:0] exp_w[3];
    logic        rdy_snap;
    logic [2:0]  exp_sticky;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 23'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'h0, flag_invalid, flag_overflow, flag_zero}, 32'h0);
        check("rst_sticky", {29'h0, sticky}, 32'h0);

        send(2'b00, 2'b00, 2'b00, 1'b1, 8'h81, 23'h200000, 1'b0);
        check_head("norm", 32'hC0A00000, 1'b0, 1'b0, 1'b0);
        step();
        check("norm_drained", {31'h0, out_valid}, 32'h0);

        send(2'b01, 2'b10, 2'b10, 1'b0, 8'h12, 23'h1234, 1'b0);
        check_head("qnan", 32'h7FC00000, 1'b1, 1'b0, 1'b0);
        step();
        send(2'b10, 2'b01, 2'b01, 1'b0, 8'h55, 23'h7, 1'b0);
        check_head("negzero", 32'h80000000, 1'b0, 1'b0, 1'b1);
        step();

        send(2'b00, 2'b00, 2'b00, 1'b0, 8'hFE, 23'h0, 1'b1);
        check_head("ovf", 32'h7F800000, 1'b0, 1'b1, 1'b0);
        step();
        send(2'b00, 2'b01, 2'b00, 1'b0, 8'hFE, 23'h0, 1'b1);
        check_head("ovf_ignored", 32'h00000000, 1'b0, 1'b0, 1'b1);
        step();

        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_cleared0", {29'h0, sticky}, 32'h0);
        send(2'b00, 2'b00, 2'b11, 1'b0, 8'h10, 23'h0, 1'b1);
        check_head("rsvd", 32'h7FC00000, 1'b1, 1'b0, 1'b0);
        step();
`ifdef FP_PACK_STICKY_EN
        exp_sticky = 3'b101;
`else
        exp_sticky = 3'b000;
`endif
        check("sticky_after_pop", {29'h0, sticky}, {29'h0, exp_sticky});
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_cleared", {29'h0, sticky}, 32'h0);

        exp_w[0] = 32'h00800001;
        exp_w[1] = 32'h3F800000;
        exp_w[2] = 32'hC0400000;
        out_ready = 1'b0;
        send(2'b00, 2'b00, 2'b00, 1'b0, 8'h01, 23'h1, 1'b0);
        send(2'b00, 2'b00, 2'b00, 1'b0, 8'h7F, 23'h0, 1'b0);
        check("bp_full_ready", {31'h0, in_ready}, 32'h0);
        drive(2'b00, 2'b00, 2'b00, 1'b1, 8'h80, 23'h400000, 1'b0);
        in_valid = 1'b1;
        step();
        check("bp_stall_ready", {31'h0, in_ready}, 32'h0);
        check("bp_stall_hold", result, exp_w[0]);
        step();
        check("bp_stall_hold2", result, exp_w[0]);
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid)
                got_q.push_back(result);
            rdy_snap = in_ready;
            step();
            if (in_valid && rdy_snap)
                in_valid = 1'b0;
        end
        check("bp_stuck_valid", {31'h0, in_valid}, 32'h0);
        check("bp_count", got_q.size(), 32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("bp_word%0d", k), (k < got_q.size()) ? got_q[k] : 32'hDEADBEEF, exp_w[k]);

        out_ready = 1'b0;
        send(2'b00, 2'b00, 2'b00, 1'b0, 8'h40, 23'h3, 1'b0);
        send(2'b00, 2'b00, 2'b00, 1'b1, 8'h41, 23'h5, 1'b0);
        check("mid_full_valid", {31'h0, out_valid}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_valid", {31'h0, out_valid}, 32'h0);
        check("mid_result", result, 32'h0);
        check("mid_ready", {31'h0, in_ready}, 32'h1);
        check("mid_flags", {29'h0, flag_invalid, flag_overflow, flag_zero}, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        check("mid_no_ghost", {31'h0, out_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
